fifo_sync_cfg: RTL and testbench

Parametrised synchronous FIFO, next generation of the team's single-clock FIFO. Adds non-power-of-two depth, selectable first-word-fall-through (FWFT) or registered-read mode, programmable almost-full/almost-empty levels, a synchronous flush, write-through-when-full on a simultaneous pop, and sticky overflow/underflow error flags. Sits between any single-clock producer/consumer pair; all outputs derive from registered state.

---
 rtl/fifo_sync_cfg.sv | 124 ++++++++++++
 tb/tb_fifo_sync_cfg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_cfg.sv
// fifo_sync_cfg: single-clock FIFO with arbitrary depth, optional
// first-word-fall-through read, programmable almost-full/almost-empty
// thresholds, synchronous flush, write-through on a full FIFO when a pop
// is accepted in the same cycle, and sticky overflow/underflow flags.
module fifo_sync_cfg #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FWFT     = 0,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             rd_acc, wr_acc, mem_we;

  // Status flags decoded from the registered count only.
  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (AF_LEVEL != 0) && (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
  end

  // Accept decisions, pointer/count/flag next-state; flush overrides everything.
  always_comb begin
    rd_acc      = rd_en && !empty;
    wr_acc      = wr_en && (!full || rd_acc);
    mem_we      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      mem_we = wr_acc;
      if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      if (rd_acc) begin
        rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
      if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
      if (wr_en && !wr_acc) overflow_d  = 1'b1;
      if (rd_en && empty)   underflow_d = 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_data;
  end

  // When full with a pop accepted, wr_ptr equals rd_ptr: the pop reads the
  // old word at this edge while the new word lands in the same slot.
  assign rd_data   = (FWFT != 0) ? mem_q[rd_ptr_q] : rd_data_q;
  assign rd_valid  = (FWFT != 0) ? !empty : rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync_cfg.sv
// Testbench for fifo_sync_cfg: a registered-read instance (DEPTH=6,
// AF_LEVEL=4, AE_LEVEL=2) and a FWFT instance (DEPTH=6), each shadowed by
// a queue model; popped words are compared against an expected-output queue.
module tb_fifo_sync_cfg;
  localparam int D  = 6;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          fl0 = 0, we0 = 0, re0 = 0;
  logic [7:0]    wd0 = '0;
  logic [7:0]    rdd0;
  logic          rv0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [CW-1:0] cnt0;

  logic          fl1 = 0, we1 = 0, re1 = 0;
  logic [7:0]    wd1 = '0;
  logic [7:0]    rdd1;
  logic          rv1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [CW-1:0] cnt1;

  fifo_sync_cfg #(.WIDTH(8), .DEPTH(D), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(2)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(fl0), .wr_en(we0), .wr_data(wd0), .rd_en(re0),
    .rd_data(rdd0), .rd_valid(rv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(unf0));

  fifo_sync_cfg #(.WIDTH(8), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(fl1), .wr_en(we1), .wr_data(wd1), .rd_en(re1),
    .rd_data(rdd1), .rd_valid(rv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(unf1));

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] st0[$];
  logic [7:0] ex0[$];
  logic [7:0] st1[$];
  bit m_ovf0 = 0, m_unf0 = 0, m_rv0 = 0, m_unf1 = 0;

  task automatic drive0(input bit fl, input bit we, input logic [7:0] wd, input bit re);
    bit ra, wa;
    fl0 = fl; we0 = we; wd0 = wd; re0 = re;
    if (fl) begin
      st0.delete(); m_ovf0 = 0; m_unf0 = 0; m_rv0 = 0;
    end else begin
      ra = re && (st0.size() > 0);
      wa = we && ((st0.size() < D) || ra);
      if (we && !wa) m_ovf0 = 1;
      if (re && st0.size() == 0) m_unf0 = 1;
      if (ra) ex0.push_back(st0.pop_front());
      if (wa) st0.push_back(wd);
      m_rv0 = ra;
    end
    @(posedge clk); #1;
    fl0 = 0; we0 = 0; re0 = 0;
  endtask

  task automatic drive1(input bit we, input logic [7:0] wd, input bit re);
    bit ra, wa;
    we1 = we; wd1 = wd; re1 = re;
    ra = re && (st1.size() > 0);
    wa = we && ((st1.size() < D) || ra);
    if (re && st1.size() == 0) m_unf1 = 1;
    if (ra) void'(st1.pop_front());
    if (wa) st1.push_back(wd);
    @(posedge clk); #1;
    we1 = 0; re1 = 0;
  endtask

  task automatic test_reset;
    n_cmp++; if (cnt0 !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", cnt0); end
    n_cmp++; if ({empty0, full0, ae0, af0} !== 4'b1010) begin n_err++; $display("FAIL reset_flags: got %b exp 1010", {empty0, full0, ae0, af0}); end
    n_cmp++; if ({rv0, ovf0, unf0} !== 3'b000) begin n_err++; $display("FAIL reset_status: got %b exp 000", {rv0, ovf0, unf0}); end
    n_cmp++; if (rdd0 !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h exp 00", rdd0); end
    n_cmp++; if ({empty1, rv1, cnt1} !== {1'b1, 1'b0, 3'd0}) begin n_err++; $display("FAIL reset_fwft: got %b/%b/%0d exp 1/0/0", empty1, rv1, cnt1); end
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 7; i++) begin
      drive0(0, 1, 8'(i), 0);
      n_cmp++; if (cnt0 !== CW'(st0.size())) begin n_err++; $display("FAIL fill_count: got %0d exp %0d", cnt0, st0.size()); end
      n_cmp++; if (full0 !== (st0.size() == D)) begin n_err++; $display("FAIL fill_full: got %b at count %0d", full0, st0.size()); end
      n_cmp++; if (af0 !== (st0.size() >= 4)) begin n_err++; $display("FAIL fill_almost_full: got %b at count %0d", af0, st0.size()); end
      n_cmp++; if (ae0 !== (st0.size() <= 2)) begin n_err++; $display("FAIL fill_almost_empty: got %b at count %0d", ae0, st0.size()); end
      n_cmp++; if (ovf0 !== m_ovf0) begin n_err++; $display("FAIL fill_overflow: got %b exp %b at push %0d", ovf0, m_ovf0, i); end
    end
    n_cmp++; if ({ovf0, full0, cnt0} !== {1'b1, 1'b1, 3'd6}) begin n_err++; $display("FAIL overflow_final: got %b/%b/%0d exp 1/1/6", ovf0, full0, cnt0); end
  endtask

  task automatic test_drain;
    logic [7:0] e;
    for (int i = 1; i <= 6; i++) begin
      drive0(0, 0, 8'h00, 1);
      n_cmp++; if (rv0 !== 1'b1) begin n_err++; $display("FAIL drain_valid: got %b exp 1", rv0); end
      e = ex0.pop_front();
      n_cmp++; if (rdd0 !== e || e !== 8'(i)) begin n_err++; $display("FAIL drain_data: got %h exp %h", rdd0, 8'(i)); end
    end
    drive0(0, 0, 8'h00, 1);
    n_cmp++; if ({rv0, unf0, empty0} !== 3'b011) begin n_err++; $display("FAIL underflow: got %b exp 011", {rv0, unf0, empty0}); end
    drive0(0, 0, 8'h00, 0);
    n_cmp++; if (rdd0 !== 8'h06) begin n_err++; $display("FAIL rd_data_hold: got %h exp 06", rdd0); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) drive0(0, 1, 8'(8'h21 + i), 0);
    n_cmp++; if ({cnt0, ovf0, unf0} !== {3'd3, 1'b1, 1'b1}) begin n_err++; $display("FAIL preflush: got %0d/%b/%b exp 3/1/1", cnt0, ovf0, unf0); end
    drive0(1, 1, 8'hEE, 1);
    n_cmp++; if ({cnt0, empty0, ovf0, unf0, rv0} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin n_err++; $display("FAIL flush_state: got cnt %0d empty %b ovf %b unf %b rv %b exp 0 1 0 0 0", cnt0, empty0, ovf0, unf0, rv0); end
    n_cmp++; if (rdd0 !== 8'h06) begin n_err++; $display("FAIL flush_rd_data_hold: got %h exp 06", rdd0); end
    drive0(0, 1, 8'h33, 0);
    drive0(0, 0, 8'h00, 1);
    n_cmp++; if (rdd0 !== ex0.pop_front() || rdd0 !== 8'h33 || empty0 !== 1'b1) begin n_err++; $display("FAIL flush_no_write: got %h empty %b exp 33 1", rdd0, empty0); end
  endtask

  task automatic test_write_through;
    logic [7:0] e;
    for (int i = 0; i < 6; i++) drive0(0, 1, 8'(8'h10 + i), 0);
    drive0(0, 1, 8'hAA, 1);
    n_cmp++; if ({cnt0, ovf0, rv0} !== {3'd6, 1'b0, 1'b1}) begin n_err++; $display("FAIL wt_state: got %0d/%b/%b exp 6/0/1", cnt0, ovf0, rv0); end
    e = ex0.pop_front();
    n_cmp++; if (rdd0 !== e) begin n_err++; $display("FAIL wt_pop0: got %h exp %h", rdd0, e); end
    for (int i = 0; i < 6; i++) begin
      drive0(0, 0, 8'h00, 1);
      e = ex0.pop_front();
      n_cmp++; if (rdd0 !== e) begin n_err++; $display("FAIL wt_pop: got %h exp %h", rdd0, e); end
    end
    n_cmp++; if (rdd0 !== 8'hAA) begin n_err++; $display("FAIL wt_sixth: got %h exp aa", rdd0); end
  endtask

  task automatic test_stream;
    logic [7:0] e;
    for (int i = 0; i < 22; i++) begin
      drive0(0, i < 20, 8'(8'h40 + i), i >= 2);
      n_cmp++; if (cnt0 !== CW'(st0.size()) || cnt0 > 3'd6) begin n_err++; $display("FAIL stream_count: got %0d exp %0d", cnt0, st0.size()); end
      if (m_rv0) begin
        e = ex0.pop_front();
        n_cmp++; if (rv0 !== 1'b1 || rdd0 !== e) begin n_err++; $display("FAIL stream_data: got %h/%b exp %h/1", rdd0, rv0, e); end
      end
    end
    n_cmp++; if ({empty0, ex0.size() == 0} !== 2'b11) begin n_err++; $display("FAIL stream_end: got empty %b pending %0d exp 1 0", empty0, ex0.size()); end
  endtask

  task automatic test_fwft;
    drive1(1, 8'h55, 0);
    n_cmp++; if ({rv1, empty1, rdd1} !== {1'b1, 1'b0, 8'h55}) begin n_err++; $display("FAIL fwft_show: got %b/%b/%h exp 1/0/55", rv1, empty1, rdd1); end
    drive1(0, 8'h00, 1);
    n_cmp++; if ({rv1, empty1} !== 2'b01) begin n_err++; $display("FAIL fwft_ack: got %b/%b exp 0/1", rv1, empty1); end
    drive1(0, 8'h00, 1);
    n_cmp++; if (unf1 !== m_unf1 || unf1 !== 1'b1) begin n_err++; $display("FAIL fwft_underflow: got %b exp 1", unf1); end
    for (int i = 0; i < 3; i++) drive1(1, 8'(8'h61 + i), 0);
    while (st1.size() > 0) begin
      n_cmp++; if (rv1 !== 1'b1 || rdd1 !== st1[0]) begin n_err++; $display("FAIL fwft_head: got %h/%b exp %h/1", rdd1, rv1, st1[0]); end
      drive1(0, 8'h00, 1);
    end
    n_cmp++; if ({rv1, empty1, cnt1} !== {1'b0, 1'b1, 3'd0}) begin n_err++; $display("FAIL fwft_drained: got %b/%b/%0d exp 0/1/0", rv1, empty1, cnt1); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) drive0(0, 1, 8'(8'h71 + i), 0);
    drive0(0, 0, 8'h00, 1);
    n_cmp++; if ({rv0, cnt0} !== {1'b1, 3'd2}) begin n_err++; $display("FAIL prereset: got %b/%0d exp 1/2", rv0, cnt0); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({cnt0, empty0, full0, ae0, af0} !== {3'd0, 4'b1010}) begin n_err++; $display("FAIL async_reset_flags: got %0d %b exp 0 1010", cnt0, {empty0, full0, ae0, af0}); end
    n_cmp++; if ({rv0, ovf0, unf0, rdd0} !== {3'b000, 8'h00}) begin n_err++; $display("FAIL async_reset_data: got %b %h exp 000 00", {rv0, ovf0, unf0}, rdd0); end
    n_cmp++; if (unf1 !== 1'b0) begin n_err++; $display("FAIL async_reset_fwft_unf: got %b exp 0", unf1); end
    st0.delete(); ex0.delete(); st1.delete();
    m_ovf0 = 0; m_unf0 = 0; m_rv0 = 0; m_unf1 = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive0(0, 1, 8'h99, 0);
    drive0(0, 0, 8'h00, 1);
    n_cmp++; if (rdd0 !== ex0.pop_front() || rdd0 !== 8'h99) begin n_err++; $display("FAIL post_reset: got %h exp 99", rdd0); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fill_overflow();
    test_drain();
    test_flush();
    test_write_through();
    test_stream();
    test_fwft();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
